// File: rtl/dadda_div16x8.sv
// Iterative restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per cycle.
// Divide-by-zero and quotient-overflow are resolved at acceptance without iterating.
module dadda_div16x8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [WIDTH:0]     part_rem;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   div_reg;
  logic [CNT_W-1:0]   count;

  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     trial_diff;
  logic [WIDTH:0]     rem_next;
  logic               trial_ge;
  logic [WIDTH-1:0]   shreg_next;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  // R stays below the divisor, so its top bit is zero; folding it in keeps the compare total.
  assign trial      = {part_rem[WIDTH-1:0], shreg[WIDTH-1]};
  assign trial_ge   = part_rem[WIDTH] | (trial >= {1'b0, div_reg});
  assign trial_diff = trial - {1'b0, div_reg};
  assign rem_next   = trial_ge ? trial_diff : trial;
  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign shreg_next = {shreg[WIDTH-2:0], trial_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      part_rem  <= '0;
      shreg     <= '0;
      div_reg   <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            div_reg  <= divisor;
            if (divisor == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              div_zero  <= 1'b1;
              overflow  <= 1'b0;
              quotient  <= '1;
              remainder <= dividend[WIDTH-1:0];
            end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
              state     <= DONE;
              out_valid <= 1'b1;
              div_zero  <= 1'b0;
              overflow  <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[WIDTH-1:0];
            end else begin
              state    <= CALC;
              div_zero <= 1'b0;
              overflow <= 1'b0;
              part_rem <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
              shreg    <= dividend[WIDTH-1:0];
              count    <= CNT_W'(WIDTH);
            end
          end
        end
        CALC: begin
          part_rem <= rem_next;
          shreg    <= shreg_next;
          count    <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= shreg_next;
            remainder <= rem_next[WIDTH-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dadda_div16x8.md
Name: dadda_div16x8

Overview:
- Iterative restoring divider: the inverse operation of the team's 8x8 Dadda multiplier.
- Takes a 2*WIDTH-bit dividend (typically a multiplier product) and a WIDTH-bit divisor.
- Returns a WIDTH-bit quotient and remainder, with divide-by-zero and quotient-overflow flags.
- Sits downstream of the multiplier in the arithmetic datapath, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH bits.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  dividend/divisor valid
in_ready  output  1  block can accept an operand pair
dividend  input  2*WIDTH  numerator, unsigned
divisor  input  WIDTH  denominator, unsigned
out_valid  output  1  result valid; held until accepted
out_ready  input  1  consumer accepts result
quotient  output  WIDTH  unsigned quotient
remainder  output  WIDTH  unsigned remainder
div_zero  output  1  divisor was 0
overflow  output  1  quotient does not fit in WIDTH bits

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - quotient = 0; remainder = 0; div_zero = 0; overflow = 0.
  - Internal partial remainder, dividend shift register and counter = 0.
- States:
  - IDLE: in_ready = 1. On in_valid, the operands are captured; in_ready drops the next cycle.
    - divisor == 0: go to DONE; div_zero = 1, quotient = all-ones, remainder = dividend[WIDTH-1:0].
    - Else if dividend[2W-1:W] >= divisor: go to DONE; overflow = 1, quotient = all-ones, remainder = dividend[WIDTH-1:0].
    - Else: go to CALC. Partial remainder R (WIDTH+1 bits) = {0, dividend[2W-1:W]}; low half goes to the shift register; count = WIDTH.
  - CALC: one quotient bit per cycle, MSB first.
    - T = {R[W-1:0], next dividend bit}.
    - If T >= divisor: R = T - divisor and shift in 1. Else: R = T and shift in 0.
    - Decrement count. On the last iteration (count == 1), go to DONE.
  - DONE: out_valid = 1.
    - quotient, remainder, div_zero and overflow are stable while out_valid && !out_ready.
    - On out_ready, go to IDLE; out_valid falls the next cycle; flags clear on the next acceptance.
- Latency, with the acceptance edge as cycle 0:
  - Normal divide: out_valid asserted in cycle WIDTH+1 (cycle 9 for WIDTH=8).
  - Zero or overflow: out_valid asserted in cycle 1.
- Throughput: at most one operation in flight. in_ready = 1 only in IDLE. Operands offered during CALC or DONE are ignored, not queued.
- Simultaneous out_ready in DONE and in_valid: the new operand is not accepted that cycle; it is accepted the following cycle (IDLE).
- Invariant in normal mode: quotient*divisor + remainder == dividend, and remainder < divisor.
- div_zero takes priority over overflow; both are never set together.
- Reset mid-operation (CALC or DONE) aborts the operation: all outputs return to reset values the next cycle and the result is discarded.
- No combinational path from in_valid to in_ready or from out_ready to out_valid; all outputs are registered.

Test Plan:
- Basic divide: dividend 0x03E8, divisor 0x07 -> quotient 0x8E, remainder 0x06, flags 0, out_valid in cycle 9.
- Multiplier round-trip: dividend 0xFE01, divisor 0xFF -> quotient 0xFF, remainder 0x00. Also dividend 0xFEFF, divisor 0xFF -> quotient 0xFF, remainder 0xFE.
- Error paths:
  - dividend 0x1234, divisor 0x00 -> div_zero 1, quotient 0xFF, remainder 0x34, out_valid in cycle 1.
  - dividend 0xFF00, divisor 0xFF -> overflow 1, quotient 0xFF, remainder 0x00.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid -> outputs stable; in_ready stays 0; in_valid pulses during CALC/DONE are ignored. Raise out_ready -> next operand accepted one cycle after out_valid falls.
- Reset mid-CALC: assert rst in cycle 4 of 0x03E8/0x07 -> next cycle out_valid 0, in_ready 1, outputs 0. A following 0x0064/0x0A then gives quotient 0x0A, remainder 0x00.
- Random sweep: 10k random operand pairs with random out_ready stalls -> compare against a reference model (q = a/b, r = a%b, flags as specified); no lost or duplicated results.
